// File: rtl/sd_dat_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sd_dat_pkg
//  Purpose  : Shared types and constants for the SD DAT0 data path:
//             transmitter state encoding, CRC16 polynomial, framing bits
//             and the on-line block length.
//  Revision : 1.0 - initial release
// ============================================================================
package sd_dat_pkg;

    // Transmitter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_CRC   = 3'd4,
        ST_END   = 3'd5
    } tx_state_t;

    // CRC16-CCITT, x^16 + x^12 + x^5 + 1, the x^16 term is implicit
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam int unsigned CRC_BITS   = 16;

    // Framing bits on DAT0
    localparam logic START_BIT = 1'b0;
    localparam logic END_BIT   = 1'b1;

    // Cycles one block occupies on the line: start, data, CRC, end
    function automatic int unsigned block_length(input int unsigned words);
        return 1 + 32 * words + CRC_BITS + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc16.sv
`default_nettype none
// ============================================================================
//  Module   : sd_crc16
//  Purpose  : Bit-serial CRC16-CCITT (init 0). One message bit is folded in
//             per enabled cycle. Feeding bit_in = crc[15] makes the feedback
//             zero, so the remainder simply shifts out MSB first.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_crc16
    import sd_dat_pkg::*;
(
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] r_crc;
    logic        w_feedback;

    assign w_feedback = bit_in ^ r_crc[15];

    // Remainder register; clear wins so a fresh block always starts from zero
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            r_crc <= '0;
        end else if (clear) begin
            r_crc <= '0;
        end else if (enable) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_feedback ? CRC16_POLY : 16'h0000);
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sd_card_dat_tx.sv
`default_nettype none
// ============================================================================
//  Module   : sd_card_dat_tx
//  Purpose  : Card-side DAT0 transmitter for SD read transfers. Pulls 32-bit
//             words from the block buffer and sends one or more blocks, each
//             framed as start bit, data (MSB first), CRC16 and end bit, with
//             an Nac idle gap ahead of every start bit.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_card_dat_tx
    import sd_dat_pkg::*;
#(
    parameter int BLOCK_WORDS = 128,
    parameter int NAC_CYCLES  = 2
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  blocks,
    input  logic        abort,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        dat_out,
    output logic        dat_oe,
    output logic        busy,
    output logic        complete,
    output logic        underrun
);

    // The first word is taken inside WAIT, so at least one WAIT cycle exists
    localparam int c_nac_eff   = (NAC_CYCLES < 1) ? 1 : NAC_CYCLES;
    localparam int c_nac_w     = (c_nac_eff > 1) ? $clog2(c_nac_eff) : 1;
    localparam int c_words_eff = (BLOCK_WORDS < 1) ? 1 : BLOCK_WORDS;
    localparam int c_word_w    = (c_words_eff > 1) ? $clog2(c_words_eff) : 1;

    localparam logic [c_nac_w-1:0]  c_nac_last  = c_nac_w'(c_nac_eff - 1);
    localparam logic [c_word_w-1:0] c_word_last = c_word_w'(c_words_eff - 1);
    // With a single Nac cycle the buffer is asked for a word on WAIT entry
    localparam logic                c_ready_on_entry = (c_nac_eff == 1);

    tx_state_t           r_state;
    logic [3:0]          r_blocks_left;
    logic [c_nac_w-1:0]  r_nac_cnt;
    logic [c_word_w-1:0] r_word_cnt;
    logic [4:0]          r_bit_cnt;
    logic [3:0]          r_crc_cnt;
    logic [31:0]         r_shift;
    logic                r_dat_out;
    logic                r_dat_oe;
    logic                r_data_ready;
    logic                r_busy;
    logic                r_complete;
    logic                r_underrun;

    logic [c_nac_w-1:0]  w_nac_next;
    logic [31:0]         w_next_word;
    logic                w_crc_clear;
    logic                w_crc_enable;
    logic                w_crc_bit;
    logic [15:0]         w_crc;

    // Nac counter saturates at its last value so it can never wrap
    assign w_nac_next  = (r_nac_cnt == c_nac_last) ? r_nac_cnt : r_nac_cnt + 1'b1;

    // A missing mid-block word is replaced by zeros and sent anyway
    assign w_next_word = data_valid ? data_in : 32'h0000_0000;

    // CRC restarts on the first-word handshake, covers every bit actually
    // driven in DATA, then shifts its own remainder out during CRC
    assign w_crc_clear  = (r_state == ST_WAIT) && r_data_ready && data_valid;
    assign w_crc_enable = (r_state == ST_DATA) || (r_state == ST_CRC);
    assign w_crc_bit    = (r_state == ST_CRC) ? w_crc[15] : r_dat_out;

    sd_crc16 u_crc16 (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (w_crc_clear),
        .enable   (w_crc_enable),
        .bit_in   (w_crc_bit),
        .crc      (w_crc)
    );

    // Transfer sequencer: state, counters, shift register and all outputs
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_blocks_left <= '0;
            r_nac_cnt     <= '0;
            r_word_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_crc_cnt     <= '0;
            r_shift       <= '0;
            r_dat_out     <= 1'b1;
            r_dat_oe      <= 1'b0;
            r_data_ready  <= 1'b0;
            r_busy        <= 1'b0;
            r_complete    <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            if (abort) begin
                // Stop transmission: release the line at once, keep underrun
                r_state      <= ST_IDLE;
                r_dat_oe     <= 1'b0;
                r_dat_out    <= 1'b1;
                r_busy       <= 1'b0;
                r_data_ready <= 1'b0;
                r_nac_cnt    <= '0;
                r_word_cnt   <= '0;
                r_bit_cnt    <= '0;
                r_crc_cnt    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && (blocks != 4'd0)) begin
                            r_state       <= ST_WAIT;
                            r_blocks_left <= blocks;
                            r_busy        <= 1'b1;
                            r_underrun    <= 1'b0;
                            r_nac_cnt     <= '0;
                            r_data_ready  <= c_ready_on_entry;
                        end
                    end

                    ST_WAIT: begin
                        if (r_data_ready && data_valid) begin
                            r_state      <= ST_START;
                            r_shift      <= data_in;
                            r_data_ready <= 1'b0;
                            r_dat_oe     <= 1'b1;
                            r_dat_out    <= START_BIT;
                            r_bit_cnt    <= 5'd31;
                            r_word_cnt   <= '0;
                        end else begin
                            // Stay here as long as the buffer has nothing
                            r_nac_cnt    <= w_nac_next;
                            r_data_ready <= (w_nac_next == c_nac_last);
                        end
                    end

                    ST_START: begin
                        r_state   <= ST_DATA;
                        r_dat_out <= r_shift[31];
                        r_shift   <= {r_shift[30:0], 1'b0};
                    end

                    ST_DATA: begin
                        if (r_bit_cnt != 5'd0) begin
                            r_dat_out    <= r_shift[31];
                            r_shift      <= {r_shift[30:0], 1'b0};
                            r_bit_cnt    <= r_bit_cnt - 5'd1;
                            // Ask for the next word while bit 0 is on the line
                            r_data_ready <= (r_bit_cnt == 5'd1) && (r_word_cnt != c_word_last);
                        end else if (r_word_cnt != c_word_last) begin
                            r_dat_out    <= w_next_word[31];
                            r_shift      <= {w_next_word[30:0], 1'b0};
                            r_bit_cnt    <= 5'd31;
                            r_word_cnt   <= r_word_cnt + 1'b1;
                            r_data_ready <= 1'b0;
                            if (!data_valid) begin
                                r_underrun <= 1'b1;
                            end
                        end else begin
                            r_state    <= ST_CRC;
                            r_crc_cnt  <= '0;
                            r_word_cnt <= '0;
                            r_dat_out  <= END_BIT;
                        end
                    end

                    ST_CRC: begin
                        if (r_crc_cnt == 4'd15) begin
                            r_state   <= ST_END;
                            r_crc_cnt <= '0;
                            r_dat_out <= END_BIT;
                        end else begin
                            r_crc_cnt <= r_crc_cnt + 4'd1;
                        end
                    end

                    ST_END: begin
                        r_blocks_left <= r_blocks_left - 4'd1;
                        r_dat_oe      <= 1'b0;
                        r_dat_out     <= 1'b1;
                        if (r_blocks_left != 4'd1) begin
                            r_state      <= ST_WAIT;
                            r_nac_cnt    <= '0;
                            r_data_ready <= c_ready_on_entry;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_complete <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // The CRC remainder is already a register, so it drives the pad directly
    assign dat_out    = (r_state == ST_CRC) ? w_crc[15] : r_dat_out;
    assign dat_oe     = r_dat_oe;
    assign data_ready = r_data_ready;
    assign busy       = r_busy;
    assign complete   = r_complete;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_sd_card_dat_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_card_dat_tx
//  Purpose  : Scoreboard bench for sd_card_dat_tx. Stimulus pushes the
//             expected words and CRCs of every block; a line monitor decodes
//             frames from DAT0 and pops/compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_card_dat_tx;

    localparam int BW    = 128;
    localparam int NAC   = 2;
    localparam int FRAME = 1 + 32 * BW + 16 + 1;

    logic        sd_clock   = 1'b0;
    logic        reset      = 1'b0;
    logic        start      = 1'b0;
    logic [3:0]  blocks     = 4'd0;
    logic        abort      = 1'b0;
    logic [31:0] data_in    = 32'h0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        dat_out;
    logic        dat_oe;
    logic        busy;
    logic        complete;
    logic        underrun;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    sd_card_dat_tx #(.BLOCK_WORDS(BW), .NAC_CYCLES(NAC)) dut (
        .sd_clock   (sd_clock),
        .reset      (reset),
        .start      (start),
        .blocks     (blocks),
        .abort      (abort),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .dat_out    (dat_out),
        .dat_oe     (dat_oe),
        .busy       (busy),
        .complete   (complete),
        .underrun   (underrun)
    );

    always #5 sd_clock = ~sd_clock;
    always @(posedge sd_clock) cyc_n <= cyc_n + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference CRC: remainder of M(x)*x^16 divided by G(x), by long division
    function automatic logic [15:0] crc_ref(input logic [31:0] w[$]);
        logic [16:0] r;
        logic        b;
        int          nbits;
        r     = 17'h0;
        nbits = int'(w.size()) * 32;
        for (int i = 0; i < nbits + 16; i++) begin
            b = (i < nbits) ? w[i / 32][31 - (i % 32)] : 1'b0;
            r = {r[15:0], b};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    // Scoreboard queues and monitor logs
    logic [31:0] exp_words[$];
    logic [15:0] exp_crc[$];
    int          sb_q[$];
    int          end_q[$];
    int          cmp_q[$];
    int          frames      = 0;
    bit          allow_trunc = 1'b0;
    logic [15:0] last_crc    = 16'h0;

    // Line monitor: decodes frames on DAT0, stamps cycles (cycle after edge n = n+1)
    int          mpos     = 0;
    bit          in_frame = 1'b0;
    logic [31:0] macc     = 32'h0;
    logic [15:0] mcrc     = 16'h0;

    always @(negedge sd_clock) begin
        if (!reset) begin
            in_frame = 1'b0;
        end else begin
            if (complete) cmp_q.push_back(cyc_n + 1);
            if (in_frame && !dat_oe) begin
                if (!allow_trunc) check("frame_cut_short", 32'(mpos + 1), 32'(FRAME));
                in_frame = 1'b0;
            end else if (in_frame) begin
                mpos++;
                if (mpos <= 32 * BW) begin
                    macc = {macc[30:0], dat_out};
                    if (mpos % 32 == 0) begin
                        if (exp_words.size() == 0) check("word_queue_empty", 32'd1, 32'd0);
                        else check("data_word", macc, exp_words.pop_front());
                    end
                end else if (mpos <= 32 * BW + 16) begin
                    mcrc = {mcrc[14:0], dat_out};
                    if (mpos == 32 * BW + 16) begin
                        last_crc = mcrc;
                        if (exp_crc.size() == 0) check("crc_queue_empty", 32'd1, 32'd0);
                        else check("crc16", 32'(mcrc), 32'(exp_crc.pop_front()));
                    end
                end else begin
                    check("end_bit", 32'(dat_out), 32'd1);
                    end_q.push_back(cyc_n + 1);
                    frames++;
                    in_frame = 1'b0;
                end
            end else if (dat_oe) begin
                in_frame = 1'b1;
                mpos     = 0;
                check("start_bit", 32'(dat_out), 32'd0);
                sb_q.push_back(cyc_n + 1);
            end
        end
    end

    // Buffer model: presents word[slot]; a slot is consumed whenever data_ready was high
    logic [31:0] src_words[$];
    int          src_slot       = 0;
    int          src_drop       = -1;
    bit          src_prev_ready = 1'b0;
    int          hs_cnt         = 0;

    task automatic src_step();
        if (src_prev_ready) src_slot++;
        data_in    = (src_slot < int'(src_words.size())) ? src_words[src_slot] : 32'h0;
        data_valid = (src_slot != src_drop);
        if (data_ready && data_valid) hs_cnt++;
        src_prev_ready = data_ready;
    endtask

    task automatic tick();
        @(negedge sd_clock);
        src_step();
    endtask

    task automatic reset_logs();
        sb_q.delete();
        end_q.delete();
        cmp_q.delete();
        exp_words.delete();
        exp_crc.delete();
        frames = 0;
    endtask

    // pattern 0: all ones, 1: incrementing, other: random; drop = slot sent as zeros
    task automatic start_xfer(input int nb, input int pattern, input int drop, output int k);
        logic [31:0] blk[$];
        logic [31:0] w;
        reset_logs();
        src_words.delete();
        src_slot       = 0;
        src_prev_ready = 1'b0;
        src_drop       = drop;
        hs_cnt         = 0;
        for (int b = 0; b < nb; b++) begin
            blk.delete();
            for (int i = 0; i < BW; i++) begin
                case (pattern)
                    0:       w = 32'hFFFF_FFFF;
                    1:       w = 32'(b * BW + i);
                    default: w = $urandom;
                endcase
                src_words.push_back(w);
                if (b * BW + i == drop) w = 32'h0;
                blk.push_back(w);
                exp_words.push_back(w);
            end
            exp_crc.push_back(crc_ref(blk));
        end
        data_in    = (src_words.size() > 0) ? src_words[0] : 32'h0;
        data_valid = 1'b1;
        blocks     = 4'(nb);
        start      = 1'b1;
        k          = cyc_n + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
        repeat (3) tick();
    endtask

    task automatic wait_start_bits(input int n, input int budget);
        int c;
        c = 0;
        while (int'(sb_q.size()) < n && c < budget) begin
            tick();
            c++;
        end
        if (int'(sb_q.size()) < n) check("wait_start_bit_timeout", 32'(sb_q.size()), 32'(n));
    endtask

    task automatic check_transfer(input int nb, input int k, input int exp_hs);
        check("frame_count", 32'(frames), 32'(nb));
        if (sb_q.size() > 0) check("start_bit_time", 32'(sb_q[0]), 32'(k + 1 + NAC));
        for (int i = 0; i < int'(end_q.size()) && i < int'(sb_q.size()); i++)
            check("frame_len", 32'(end_q[i] - sb_q[i] + 1), 32'(FRAME));
        for (int i = 1; i < int'(sb_q.size()) && i <= int'(end_q.size()); i++)
            check("gap", 32'(sb_q[i] - end_q[i - 1] - 1), 32'(NAC));
        check("complete_count", 32'(cmp_q.size()), 32'd1);
        if (cmp_q.size() > 0 && end_q.size() > 0)
            check("complete_time", 32'(cmp_q[0]), 32'(end_q[end_q.size() - 1] + 1));
        check("handshakes", 32'(hs_cnt), 32'(exp_hs));
        check("scoreboard_drained", 32'(exp_words.size() + exp_crc.size()), 32'd0);
    endtask

    initial begin
        int  k;
        int  nb;
        int  drop;
        bit  activity;

        // Reset state
        repeat (3) tick();
        check("rst_dat_out", 32'(dat_out), 32'd1);
        check("rst_dat_oe", 32'(dat_oe), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_complete", 32'(complete), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check("idle_busy", 32'(busy), 32'd0);

        // One block of all ones
        start_xfer(1, 0, -1, k);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_idle(FRAME + 100);
        check_transfer(1, k, BW);
        check("crc_all_ones", 32'(last_crc), 32'h7FA1);
        if (cmp_q.size() > 0 && sb_q.size() > 0)
            check("complete_after_start_bit", 32'(cmp_q[0] - sb_q[0]), 32'(FRAME));
        check("no_underrun", 32'(underrun), 32'd0);

        // Three blocks, incrementing words
        start_xfer(3, 1, -1, k);
        wait_idle(3 * (FRAME + 50));
        check_transfer(3, k, 3 * BW);

        // Word 5 of block 0 missing
        start_xfer(1, 1, 5, k);
        wait_idle(FRAME + 100);
        check_transfer(1, k, BW - 1);
        check("underrun_sticky", 32'(underrun), 32'd1);

        // Abort in the middle of the second block's data
        start_xfer(2, 2, -1, k);
        wait_start_bits(2, 2 * FRAME + 100);
        repeat (100) tick();
        allow_trunc = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_dat_oe", 32'(dat_oe), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dat_out", 32'(dat_out), 32'd1);
        check("abort_data_ready", 32'(data_ready), 32'd0);
        repeat (20) tick();
        check("abort_no_complete", 32'(cmp_q.size()), 32'd0);
        check("abort_frames", 32'(frames), 32'd1);
        allow_trunc = 1'b0;
        start_xfer(1, 2, -1, k);
        wait_idle(FRAME + 100);
        check_transfer(1, k, BW);

        // Asynchronous reset during the CRC field
        start_xfer(1, 2, -1, k);
        wait_start_bits(1, FRAME);
        while (sb_q.size() > 0 && cyc_n + 1 < sb_q[0] + 1 + 32 * BW + 6) tick();
        allow_trunc = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("arst_dat_oe", 32'(dat_oe), 32'd0);
        check("arst_dat_out", 32'(dat_out), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_data_ready", 32'(data_ready), 32'd0);
        check("arst_complete", 32'(complete), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        activity = 1'b0;
        repeat (30) begin
            tick();
            if (busy || dat_oe || data_ready) activity = 1'b1;
        end
        check("idle_after_reset", 32'(activity), 32'd0);
        check("no_complete_after_reset", 32'(cmp_q.size()), 32'd0);
        allow_trunc = 1'b0;

        // Zero block count, then a start while busy
        reset_logs();
        blocks = 4'd0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        activity = 1'b0;
        repeat (20) begin
            tick();
            if (busy || dat_oe || data_ready) activity = 1'b1;
        end
        check("zero_blocks_noop", 32'(activity), 32'd0);
        start_xfer(1, 1, -1, k);
        repeat (50) tick();
        blocks = 4'd3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(FRAME + 100);
        check_transfer(1, k, BW);
        repeat (20) tick();
        check("busy_start_ignored", 32'(frames), 32'd1);

        // Random transfers, some with a missing mid-block word
        for (int t = 0; t < 2; t++) begin
            nb   = $urandom_range(1, 2);
            drop = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, nb - 1)) * BW + $urandom_range(1, BW - 1)) : -1;
            start_xfer(nb, 2, drop, k);
            wait_idle(nb * (FRAME + 50));
            check_transfer(nb, k, nb * BW - ((drop >= 0) ? 1 : 0));
            check("rand_underrun", 32'(underrun), 32'((drop >= 0) ? 1 : 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
